sent_tx_fast_ch_sched: RTL
==========================

Name: sent_tx_fast_ch_sched

Overview:
Scheduler for the SENT TX fast-channel data register. For each frame request it drives the register's one-hot load strobes in the order the configured fast-channel format requires. It tracks completion and checks that both byte FIFOs hold enough data beforehand. It then presents the assembled F1/F2 words to the frame builder with a valid/ack handshake, and flags timeouts and overruns.

Parameters:
TIMEOUT_CYC, 64, max cycles a single load strobe may stay high before abort
FIFO_AW, 4, FIFO level width minus 1 (level ports are FIFO_AW+1 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cfg_en  in  1  scheduler enable
cfg_fmt  in  3  0: F1 12b/F2 12b; 1: F1 14b/F2 10b; 2: F1 16b/F2 8b; 3: F1 12b only; 4-7 reserved
err_clr  in  1  clears sticky errors (pulse)
frame_req  in  1  frame builder requests next payload (1-cycle pulse)
frame_ack  in  1  frame builder consumed payload
fifo_lvl_f1  in  FIFO_AW+1  bytes available in F1 FIFO
fifo_lvl_f2  in  FIFO_AW+1  bytes available in F2 FIFO
done_f1  in  1  F1 word complete (1-cycle pulse)
done_f2  in  1  F2 word complete (1-cycle pulse)
rd_en_f2  in  1  F2 FIFO read strobe (completion source for 8-bit F2)
load_12bit_f1, load_14bit_f1, load_16bit_f1  out  1 each  F1 load strobes
load_8bit_f2, load_10bit_f2, load_12bit_f2  out  1 each  F2 load strobes
frame_valid  out  1  payload in data register is stable
fifo_starve  out  1  waiting for FIFO bytes
busy  out  1  not in IDLE
err_timeout  out  1  sticky timeout error
err_overrun  out  1  sticky request-overrun error
err_fmt  out  1  sticky reserved-format error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, phase counters 0, pending 0.
- frame_req sets pending. A frame_req while pending is already 1 sets err_overrun; the extra request is dropped.
- States: IDLE, CHK, LD_F1, LD_F2, SETTLE, VALID.
- IDLE -> CHK when pending & cfg_en. cfg_fmt is latched into fmt_q at this transition and is ignored until the next IDLE. pending clears on entry to CHK.
- A reserved format seen at latch time sets err_fmt and returns to IDLE.
- Bytes needed per fetch, indexed by phase counter:
  - F1 14b: 2,2,2,1 (4 phases)
  - F1 12b: 2,1
  - F1 16b: 2
  - F2 10b: 2,2,2,1
  - F2 12b: 2,1
  - F2 8b: 1
- CHK: if both FIFO levels are at least the current need (F2 ignored in format 3), go to LD_F1. Otherwise stay in CHK with fifo_starve=1.
- LD_F1: exactly the format's F1 strobe is high. Completion is done_f1 for 12b/14b and done_f2 for 16b (the data register reports 16-bit F1 completion on done_f2). On completion: advance the F1 phase (wrap at phase count) and go to LD_F2, or to SETTLE for format 3.
- LD_F2: exactly the format's F2 strobe is high. Completion is done_f2 for 10b/12b and rd_en_f2 for 8b. On completion: advance the F2 phase and go to SETTLE.
- Strobes are registered and drop in the cycle after the completion pulse. Load strobes are one-hot or all zero at all times.
- SETTLE: one cycle, so the data register's negedge update has landed. Then go to VALID.
- VALID: frame_valid=1 until frame_ack is sampled high, then IDLE. frame_ack outside VALID is ignored.
- Latency: the first strobe rises 2 cycles after frame_req from IDLE.
- Timeout: a cycle counter clears on entry to each LD state. If it reaches TIMEOUT_CYC:
  - set err_timeout and drop all strobes;
  - reset both phase counters to 0;
  - go to IDLE without asserting frame_valid.
- cfg_en low mid-frame: the current frame completes; no new frame starts.
- fmt_q differing from the previous frame's format resets both phase counters before CHK evaluates.
- err_clr clears all sticky errors. If err_clr and a new error event occur in the same cycle, the error stays set.
- busy = (state != IDLE).
- Asynchronous reset mid-operation returns everything to reset values immediately.

Test Plan:
- fmt=0, levels 8/8, frame_req: load_12bit_f1 rises at cycle 2 and falls 1 cycle after done_f1. load_12bit_f2 follows and falls 1 cycle after done_f2. frame_valid rises 2 cycles after done_f2 and falls after frame_ack.
- fmt=1, 4 consecutive frames with FIFOs full: the F1 phase sequence needs 2,2,2,1 bytes. With fifo_lvl_f1=1 at phase 0, fifo_starve=1 and no strobe; raising the level to 2 starts LD_F1 next cycle.
- fmt=2: load_16bit_f1 completes on a done_f2 pulse. load_8bit_f2 completes on rd_en_f2. No done_f1 is required.
- No completion pulse for TIMEOUT_CYC=64 cycles: strobe drops, err_timeout=1, frame_valid never asserted, busy=0. err_clr then clears err_timeout.
- Two frame_req pulses while busy: err_overrun=1 and exactly one extra frame is processed afterwards. fmt=5 gives err_fmt=1 with no strobe activity.
- Reset asserted (low) during LD_F2: all strobes and frame_valid are 0 immediately. After release the FSM is in IDLE with phases 0.

Source files
------------

// File: rtl/sent_tx_fast_ch_sched.sv
// Sequences the SENT fast-channel data register's load strobes for each frame request,
// gates each frame on FIFO fill levels, and hands the assembled F1/F2 words to the frame builder.
module sent_tx_fast_ch_sched #(
  parameter int TIMEOUT_CYC = 64,
  parameter int FIFO_AW     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [2:0]       cfg_fmt,
  input  logic             err_clr,
  input  logic             frame_req,
  input  logic             frame_ack,
  input  logic [FIFO_AW:0] fifo_lvl_f1,
  input  logic [FIFO_AW:0] fifo_lvl_f2,
  input  logic             done_f1,
  input  logic             done_f2,
  input  logic             rd_en_f2,
  output logic             load_12bit_f1,
  output logic             load_14bit_f1,
  output logic             load_16bit_f1,
  output logic             load_8bit_f2,
  output logic             load_10bit_f2,
  output logic             load_12bit_f2,
  output logic             frame_valid,
  output logic             fifo_starve,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic             err_fmt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FIFO_AW:0] ONE = 1;
  localparam logic [FIFO_AW:0] TWO = 2;

  typedef enum logic [2:0] {IDLE, CHK, LD_F1, LD_F2, SETTLE, VALID} state_t;

  state_t          state;
  logic            pending;
  logic [2:0]      fmt_q;
  logic [1:0]      ph_f1;
  logic [1:0]      ph_f2;
  logic [TW-1:0]   tmo_cnt;
  // ld_f1 bits: 12b/14b/16b, ld_f2 bits: 8b/10b/12b
  logic [2:0]      ld_f1;
  logic [2:0]      ld_f2;

  logic [1:0]      last_f1;
  logic [1:0]      last_f2;
  logic [2:0]      sel_f1;
  logic [2:0]      sel_f2;
  logic [FIFO_AW:0] need_f1;
  logic [FIFO_AW:0] need_f2;
  logic            lvl_ok;
  logic            f1_done;
  logic            f2_done;
  logic            tmo_hit;
  logic            take;

  always_comb begin
    last_f1 = 2'd1;
    last_f2 = 2'd1;
    sel_f1  = 3'b001;
    sel_f2  = 3'b100;
    case (fmt_q)
      3'd1: begin last_f1 = 2'd3; last_f2 = 2'd3; sel_f1 = 3'b010; sel_f2 = 3'b010; end
      3'd2: begin last_f1 = 2'd0; last_f2 = 2'd0; sel_f1 = 3'b100; sel_f2 = 3'b001; end
      default: ;
    endcase
  end

  // The final phase of a multi-phase word fetches one byte; 16b F1 is a single 2-byte fetch
  assign need_f1 = (fmt_q == 3'd2 || ph_f1 != last_f1) ? TWO : ONE;
  assign need_f2 = (fmt_q == 3'd2) ? ONE : ((ph_f2 != last_f2) ? TWO : ONE);
  assign lvl_ok  = (fifo_lvl_f1 >= need_f1) && (fmt_q == 3'd3 || fifo_lvl_f2 >= need_f2);

  // The data register reports 16-bit F1 completion on done_f2; 8-bit F2 completes on the FIFO read
  assign f1_done = (fmt_q == 3'd2) ? done_f2 : done_f1;
  assign f2_done = (fmt_q == 3'd2) ? rd_en_f2 : done_f2;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign take    = (state == IDLE) && pending && cfg_en;

  assign load_12bit_f1 = ld_f1[0];
  assign load_14bit_f1 = ld_f1[1];
  assign load_16bit_f1 = ld_f1[2];
  assign load_8bit_f2  = ld_f2[0];
  assign load_10bit_f2 = ld_f2[1];
  assign load_12bit_f2 = ld_f2[2];
  assign fifo_starve   = (state == CHK) && !lvl_ok;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      fmt_q       <= 3'd0;
      ph_f1       <= 2'd0;
      ph_f2       <= 2'd0;
      tmo_cnt     <= '0;
      ld_f1       <= 3'b000;
      ld_f2       <= 3'b000;
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_fmt     <= 1'b0;
    end else begin
      // Clear first so a same-cycle error event below wins
      err_timeout <= err_timeout & ~err_clr;
      err_overrun <= err_overrun & ~err_clr;
      err_fmt     <= err_fmt & ~err_clr;

      if (take) pending <= 1'b0;
      if (frame_req) begin
        if (pending) err_overrun <= 1'b1;
        else         pending     <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (take) begin
            if (cfg_fmt[2]) begin
              err_fmt <= 1'b1;
            end else begin
              fmt_q <= cfg_fmt;
              if (cfg_fmt != fmt_q) begin
                ph_f1 <= 2'd0;
                ph_f2 <= 2'd0;
              end
              state <= CHK;
            end
          end
        end
        CHK: begin
          if (lvl_ok) begin
            state   <= LD_F1;
            ld_f1   <= sel_f1;
            tmo_cnt <= '0;
          end
        end
        LD_F1: begin
          if (f1_done) begin
            ld_f1 <= 3'b000;
            ph_f1 <= (ph_f1 == last_f1) ? 2'd0 : ph_f1 + 2'd1;
            if (fmt_q == 3'd3) begin
              state <= SETTLE;
            end else begin
              state   <= LD_F2;
              ld_f2   <= sel_f2;
              tmo_cnt <= '0;
            end
          end else if (tmo_hit) begin
            ld_f1       <= 3'b000;
            ph_f1       <= 2'd0;
            ph_f2       <= 2'd0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        LD_F2: begin
          if (f2_done) begin
            ld_f2 <= 3'b000;
            ph_f2 <= (ph_f2 == last_f2) ? 2'd0 : ph_f2 + 2'd1;
            state <= SETTLE;
          end else if (tmo_hit) begin
            ld_f2       <= 3'b000;
            ph_f1       <= 2'd0;
            ph_f2       <= 2'd0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SETTLE: begin
          state       <= VALID;
          frame_valid <= 1'b1;
        end
        VALID: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
